// File: rtl/ttlx8_pkg.sv
// ttlx8_pkg: shared constants, command layout and channel state for the TTL pulse shaper
package ttlx8_pkg;
    localparam int CH_NUM = 8;
    localparam int WORD_W = 8;
    localparam int DUR_W  = 10;
    localparam int CMD_W  = 16;

    localparam int EN_BIT    = 15;
    localparam int LVL_BIT   = 14;
    localparam int PMODE_BIT = 13;
    localparam int FINE_LSB  = 10;
    localparam int DUR_LSB   = 0;

    typedef struct packed {
        logic             en;
        logic             lvl;
        logic             pmode;
        logic [2:0]       fine;
        logic [DUR_W-1:0] dur;
    } ttl_cmd_t;

    typedef enum logic {IDLE, PULSE} pulse_state_t;

    // Word with bits below pos at from_lvl and bits at/above pos at to_lvl.
    function automatic logic [WORD_W-1:0] edge_word(input logic from_lvl, input logic to_lvl,
                                                    input logic [2:0] pos);
        logic [WORD_W-1:0] m;
        m = 8'hFF << pos;
        return ({WORD_W{to_lvl}} & m) | ({WORD_W{from_lvl}} & ~m);
    endfunction
endpackage

// File: rtl/ttlx8_pulse_shaper_channel.sv
// ttl_pulse_channel: one TTL channel - edge placement, self-terminating pulse, collision flag
//   clk, reset : clock, synchronous active-high reset
//   selected   : command strobe; cmd_bits valid in the same cycle
//   cmd_bits   : 16-bit channel command
//   word       : 8-bit serializer word, bit 0 first
//   level      : settled level of the line
//   active     : return edge pending
//   collision  : new command cancelled a return edge due this cycle
module ttl_pulse_channel
    import ttlx8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              selected,
    input  logic [CMD_W-1:0]  cmd_bits,
    output logic [WORD_W-1:0] word,
    output logic              level,
    output logic              active,
    output logic              collision
);
    ttl_cmd_t          cmd;
    pulse_state_t      state, state_n;
    logic [DUR_W-1:0]  cnt, cnt_n;
    logic [2:0]        fine, fine_n;
    logic [WORD_W-1:0] word_n;
    logic              level_n, coll_n, go, pcmd, due;

    assign cmd    = ttl_cmd_t'(cmd_bits);
    assign go     = selected && cmd.en;
    assign pcmd   = cmd.pmode && cmd.dur != '0;
    // Counter holds cycles left until the return word; 1 means it is registered this edge.
    assign due    = state == PULSE && cnt == DUR_W'(1);
    assign active = state == PULSE;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fine_n  = fine;
        level_n = level;
        word_n  = {WORD_W{level}};
        coll_n  = 1'b0;
        if (go) begin
            word_n  = edge_word(level, cmd.lvl, cmd.fine);
            level_n = cmd.lvl;
            fine_n  = cmd.fine;
            coll_n  = due;
            state_n = pcmd ? PULSE : IDLE;
            cnt_n   = pcmd ? cmd.dur : '0;
        end else if (state == PULSE) begin
            cnt_n = cnt - DUR_W'(1);
            if (due) begin
                word_n  = edge_word(level, !level, fine);
                level_n = !level;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            fine      <= '0;
            level     <= 1'b0;
            word      <= '0;
            collision <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            fine      <= fine_n;
            level     <= level_n;
            word      <= word_n;
            collision <= coll_n;
        end
    end
endmodule

// File: rtl/ttlx8_pulse_shaper.sv
// ttlx8_pulse_shaper: 8-channel timed edge/pulse encoder feeding OSERDESE3 8:1 serializers
//   clk, reset   : clock (also CLKDIV), synchronous active-high reset
//   selected     : command strobe from GPO_Core
//   gpo_out      : channel n command at [16n+15:16n]
//   serdes_data  : channel n word at [8n+7:8n]
//   level_out    : settled level per channel
//   pulse_active : return edge pending per channel
//   collision    : one-cycle cancelled-return flag per channel
module ttlx8_pulse_shaper
    import ttlx8_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     selected,
    input  logic [CH_NUM*CMD_W-1:0]  gpo_out,
    output logic [CH_NUM*WORD_W-1:0] serdes_data,
    output logic [CH_NUM-1:0]        level_out,
    output logic [CH_NUM-1:0]        pulse_active,
    output logic [CH_NUM-1:0]        collision
);
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        ttl_pulse_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .selected  (selected),
            .cmd_bits  (gpo_out[c*CMD_W +: CMD_W]),
            .word      (serdes_data[c*WORD_W +: WORD_W]),
            .level     (level_out[c]),
            .active    (pulse_active[c]),
            .collision (collision[c])
        );
    end
endmodule
